// File: rtl/frame_pixel_streamer.sv
`default_nettype none
// ============================================================================
// Module      : frame_pixel_streamer
// Description : Reads a ROW_SIZE x NUM_ROWS frame from a synchronous-read
//               frame memory (1-cycle latency) and streams it in raster order
//               on a valid/ready interface, with row-end and frame-end tags.
//               A 2-entry output FIFO with a same-cycle bypass hides the read
//               latency, so continuous ready sustains 1 pixel/cycle.
// Ports       : clk, rst (async, active high)
//               start            - one-cycle pulse, accepted only when idle
//               busy / done      - frame in progress / one-cycle completion
//               mem_rd_en/addr   - read request to frame memory
//               mem_rd_data      - read data, valid 1 cycle after mem_rd_en
//               pixel_out/valid/ready, row_last, frame_last - output stream
// Revision    : 1.0 - initial release
// ============================================================================
module frame_pixel_streamer #(
  parameter int WORD_SIZE = 8,
  parameter int ROW_SIZE  = 540,
  parameter int NUM_ROWS  = 540,
  parameter int ADDR_W    = $clog2(ROW_SIZE * NUM_ROWS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 mem_rd_en,
  output logic [ADDR_W-1:0]    mem_rd_addr,
  input  logic [WORD_SIZE-1:0] mem_rd_data,
  output logic [WORD_SIZE-1:0] pixel_out,
  output logic                 pixel_valid,
  input  logic                 pixel_ready,
  output logic                 row_last,
  output logic                 frame_last
);

  localparam int c_TOTAL = ROW_SIZE * NUM_ROWS;
  localparam int c_COL_W = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
  localparam int c_ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  // FIFO entry layout: {data, row_last, frame_last}
  localparam int c_ENT_W = WORD_SIZE + 2;

  localparam logic [1:0] c_S_IDLE   = 2'd0;
  localparam logic [1:0] c_S_STREAM = 2'd1;
  localparam logic [1:0] c_S_DRAIN  = 2'd2;
  localparam logic [1:0] c_S_DONE   = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [c_COL_W-1:0] col_q, col_d;
  logic [c_ROW_W-1:0] row_q, row_d;
  logic               inflight_q, inflight_d;
  logic               rl_q, rl_d;
  logic               fl_q, fl_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [c_ENT_W-1:0] e0_q, e0_d;
  logic [c_ENT_W-1:0] e1_q, e1_d;

  logic [c_ENT_W-1:0] w_in;
  logic [c_ENT_W-1:0] w_head;
  logic               w_valid;
  logic               w_pop;
  logic [1:0]         w_left;
  logic               w_issue;
  logic               w_col_last;
  logic               w_row_last;
  logic               w_addr_last;
  logic               w_pop_st;
  logic               w_wr;
  logic [1:0]         w_base;

  // Returning read data is visible on the output in the cycle it arrives;
  // it only lands in storage if it cannot be handed over immediately.
  assign w_in    = {mem_rd_data, rl_q, fl_q};
  assign w_head  = (cnt_q != 2'd0) ? e0_q : w_in;
  assign w_valid = (cnt_q != 2'd0) || inflight_q;
  assign w_pop   = w_valid && pixel_ready;

  // Items still held after this cycle's pop; issuing is allowed while this
  // leaves room for one more, which keeps a read going every cycle under
  // continuous ready and caps total holdings at two.
  assign w_left  = cnt_q + {1'b0, inflight_q} - {1'b0, w_pop};
  assign w_issue = (state_q == c_S_STREAM) && (w_left < 2'd2);

  assign w_col_last  = (col_q == c_COL_W'(ROW_SIZE - 1));
  assign w_row_last  = (row_q == c_ROW_W'(NUM_ROWS - 1));
  assign w_addr_last = (addr_q == ADDR_W'(c_TOTAL - 1));

  // Storage update: pop shifts entry 1 forward, then the arriving word is
  // written behind whatever remains (unless it was consumed by the bypass).
  assign w_pop_st = w_pop && (cnt_q != 2'd0);
  assign w_wr     = inflight_q && !(w_pop && (cnt_q == 2'd0));
  assign w_base   = cnt_q - {1'b0, w_pop_st};

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    col_d      = col_q;
    row_d      = row_q;
    rl_d       = rl_q;
    fl_d       = fl_q;
    inflight_d = w_issue;
    cnt_d      = w_left;
    e0_d       = e0_q;
    e1_d       = e1_q;

    if (w_pop_st) begin
      e0_d = e1_q;
    end
    if (w_wr) begin
      if (w_base == 2'd0) begin
        e0_d = w_in;
      end else begin
        e1_d = w_in;
      end
    end

    // Tags are computed for the address being issued and travel with it.
    if (w_issue) begin
      rl_d = w_col_last;
      fl_d = w_col_last && w_row_last;
      if (!w_addr_last) begin
        addr_d = addr_q + ADDR_W'(1);
      end
      if (w_col_last) begin
        col_d = '0;
        row_d = w_row_last ? '0 : row_q + c_ROW_W'(1);
      end else begin
        col_d = col_q + c_COL_W'(1);
      end
    end

    case (state_q)
      c_S_IDLE: begin
        if (start) begin
          state_d    = c_S_STREAM;
          addr_d     = '0;
          col_d      = '0;
          row_d      = '0;
          inflight_d = 1'b0;
          cnt_d      = 2'd0;
        end
      end
      c_S_STREAM: begin
        if (w_issue && w_addr_last) begin
          state_d = c_S_DRAIN;
        end
      end
      c_S_DRAIN: begin
        if (w_pop && w_head[0]) begin
          state_d = c_S_DONE;
        end
      end
      default: begin
        state_d = c_S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= c_S_IDLE;
      addr_q     <= '0;
      col_q      <= '0;
      row_q      <= '0;
      inflight_q <= 1'b0;
      rl_q       <= 1'b0;
      fl_q       <= 1'b0;
      cnt_q      <= 2'd0;
      e0_q       <= '0;
      e1_q       <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      col_q      <= col_d;
      row_q      <= row_d;
      inflight_q <= inflight_d;
      rl_q       <= rl_d;
      fl_q       <= fl_d;
      cnt_q      <= cnt_d;
      e0_q       <= e0_d;
      e1_q       <= e1_d;
    end
  end

  // A write into a full FIFO means the issue credit was miscounted.
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(w_wr && (w_base == 2'd2)));

  assign busy        = (state_q == c_S_STREAM) || (state_q == c_S_DRAIN);
  assign done        = (state_q == c_S_DONE);
  assign mem_rd_en   = w_issue;
  assign mem_rd_addr = addr_q;
  assign pixel_valid = w_valid;
  assign pixel_out   = w_valid ? w_head[c_ENT_W-1:2] : '0;
  assign row_last    = w_valid && w_head[1];
  assign frame_last  = w_valid && w_head[0];

endmodule
`default_nettype wire

// File: doc/frame_pixel_streamer.md
Name: frame_pixel_streamer

Overview:
- Source end of the raster pixel stream consumed by the convolution/edge-detect pipeline.
- Reads a stored frame of ROW_SIZE x NUM_ROWS pixels from a synchronous-read frame memory (1-cycle read latency).
- Emits the pixels in raster order, one per cycle, on a valid/ready stream, with row-end and frame-end markers.
- A 2-entry output FIFO absorbs memory latency, so throughput stays at 1 pixel/cycle under continuous ready and no pixel is lost under backpressure.

Parameters:
- WORD_SIZE, 8, pixel width in bits.
- ROW_SIZE, 540, pixels per row.
- NUM_ROWS, 540, rows per frame.
- ADDR_W, $clog2(ROW_SIZE*NUM_ROWS), frame memory address width (derived).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins streaming a frame from address 0.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the final pixel handshake.
- mem_rd_en  out  1  read request to frame memory.
- mem_rd_addr  out  ADDR_W  read address, raster index row*ROW_SIZE+col.
- mem_rd_data  in  WORD_SIZE  read data, valid exactly 1 cycle after mem_rd_en.
- pixel_out  out  WORD_SIZE  streamed pixel.
- pixel_valid  out  1  pixel_out, row_last and frame_last are valid.
- pixel_ready  in  1  downstream accepts; a transfer occurs when valid && ready.
- row_last  out  1  marks the last pixel of a row (col == ROW_SIZE-1).
- frame_last  out  1  marks the final pixel of the frame.

Behaviour:
- Reset, asynchronous and active-high, drives:
  - state IDLE;
  - all counters and the FIFO to empty/0;
  - busy, done, mem_rd_en, pixel_valid, row_last and frame_last to 0;
  - mem_rd_addr and pixel_out to 0.
- Reset mid-frame discards the in-flight read and FIFO contents. There is no done pulse. The block waits in IDLE for a new start.
- FSM states are IDLE, STREAM, DRAIN, DONE.
  - IDLE: start=1 moves to STREAM next cycle. The read counter, row/col tags and FIFO are cleared, and busy=1.
  - STREAM: issue reads while the credit rule allows. After the read of index ROW_SIZE*NUM_ROWS-1 is issued, move to DRAIN.
  - DRAIN: no reads are issued. Move to DONE when the frame_last pixel handshakes.
  - DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- start is ignored in STREAM, DRAIN and DONE. It is accepted in IDLE only.
- Credit rule:
  - mem_rd_en=1 only when (FIFO occupancy + reads in flight) < 2, where reads in flight is 0 or 1.
  - The count is evaluated with the same-cycle pop credited, so continuous ready sustains 1 read per cycle.
- Read address:
  - mem_rd_addr increments by 1 on each issued read, from 0 to ROW_SIZE*NUM_ROWS-1.
  - It never wraps within a frame.
- Tag computation:
  - row_last and frame_last are computed at read-issue time from the col/row counters.
  - They are delayed 1 cycle alongside the read and pushed into the FIFO with the data.
  - col wraps ROW_SIZE-1 to 0 and increments row.
- FIFO:
  - 2 entries; each entry holds {data, row_last, frame_last}.
  - Push occurs on the cycle after mem_rd_en. Pop occurs on a handshake.
  - Simultaneous push and pop keeps occupancy unchanged.
  - Overflow is impossible by the credit rule; a push into a full FIFO is a design error (assertion).
- Output:
  - pixel_valid = FIFO non-empty.
  - pixel_out, row_last and frame_last present the head entry.
  - While valid=1 and ready=0, pixel_out and its tags stay stable.
  - Valid never drops without a handshake.
- Latency: with pixel_ready held high, the start pulse is at cycle T.
  - First read is at T+1; first pixel_valid is at T+2.
  - The last pixel transfers at T+1+ROW_SIZE*NUM_ROWS.
  - done is at T+2+ROW_SIZE*NUM_ROWS.
- Width rules: counters are sized so that ROW_SIZE-1, NUM_ROWS-1 and ROW_SIZE*NUM_ROWS-1 are representable. There is no arithmetic on pixel data (pass-through).
- Degenerate case: ROW_SIZE=1 makes every pixel row_last. NUM_ROWS=1 makes the frame_last pixel also row_last.

Test Plan:
- ROW_SIZE=4, NUM_ROWS=3, memory[i]=i+10, ready always high, start at cycle 0 -> pixels 10..21 on cycles 2..13 at 1/cycle; row_last on 13, 17 and 21; frame_last on 21 only; done at cycle 14; busy high cycles 1..13.
- Same frame, pixel_ready low on cycles 2-5 then high -> pixel 10 held stable with valid=1 on cycles 2-5; mem_rd_en low once occupancy reaches 2; all 12 pixels delivered in order with none dropped or duplicated.
- Random 50% ready over 20 frames -> output sequence and tags match the raster model; FIFO never overflows (assertion).
- start pulse asserted again mid-frame (cycle 6) -> ignored; exactly 12 pixels and a single done pulse.
- rst asserted asynchronously at cycle 7 mid-frame -> all outputs 0 immediately, no done; a fresh start then streams pixel 10 first.
- Back-to-back: a start in the cycle after done -> the second frame begins from address 0 with an identical sequence.
